// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles every signal between the two requesters, the shared ALU, the
//   response consumer and the arbiter.
//
//   Handshake rule (identical for reqN and rsp): a transfer happens on the
//   rising clk edge where valid and ready are both high. The source holds
//   valid until that edge. Payload is only meaningful while valid is high and
//   is sampled only on the transfer edge. On the request side a source may
//   drop valid or change payload while it is not being accepted. On the
//   response side the arbiter keeps rsp_valid and its payload stable until
//   the transfer.
//
//   modport slave  : the arbiter side.
//   modport master : the environment side (requesters, ALU, consumer).
//   state_dbg      : arbiter FSM state, exported for checkers.
interface alu_arbiter_if;
  // requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_ctl;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  // requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_ctl;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  // shared ALU
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  // response
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  // debug
  logic [1:0]  state_dbg;

  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b,
    input  req1_valid, req1_ctl, req1_a, req1_b,
    input  alu_out, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_ctl, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_zero,
    output state_dbg
  );

  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b,
    output req1_valid, req1_ctl, req1_a, req1_b,
    output alu_out, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_ctl, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero,
    input  state_dbg
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter that shares one combinational ALU between two
//   requesters. Each accepted operation runs through three states:
//     IDLE  : the granted requester is accepted and its ctl/a/b are registered
//             onto the ALU inputs.
//     ISSUE : the ALU result and zero flag are captured.
//     RESP  : rsp_valid is held with a stable payload until rsp_ready.
//   After a response transfer the FSM spends one IDLE cycle without
//   accepting, so every operation takes at least four cycles.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : alu_arbiter_if.slave (requests, ALU connection, response, debug)
module alu_arbiter (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]  state;
  logic        last_gnt;   // requester granted most recently
  logic        owner;      // requester that owns the operation in flight
  logic        cool;       // the IDLE cycle directly after a response
  logic [3:0]  alu_ctl_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_data_q;
  logic        rsp_zero_q;

  logic gnt0;
  logic gnt1;
  logic open;
  logic acc;

  // Requester 1 wins when it is the only one asking, or on a tie when
  // requester 0 was served last. Requester 0 wins every other case.
  always_comb begin
    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_gnt);
    gnt0 = bus.req0_valid & ~gnt1;
  end

  // rst is included so that both readies are low for the whole reset
  // pulse, even though the registered state is already IDLE.
  assign open           = (state == IDLE) & ~cool & ~rst;
  assign bus.req0_ready = open & gnt0;
  assign bus.req1_ready = open & gnt1;
  assign acc            = bus.req0_ready | bus.req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;   // requester 0 wins the first tie
      owner       <= 1'b0;
      cool        <= 1'b0;
      alu_ctl_q   <= 4'b0000;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cool <= 1'b0;
          if (acc) begin
            // Unknown ctl codes are passed through untouched.
            alu_ctl_q <= gnt1 ? bus.req1_ctl : bus.req0_ctl;
            alu_a_q   <= gnt1 ? bus.req1_a   : bus.req0_a;
            alu_b_q   <= gnt1 ? bus.req1_b   : bus.req0_b;
            owner     <= gnt1;
            last_gnt  <= gnt1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data_q  <= bus.alu_out;
          rsp_zero_q  <= bus.alu_zero;
          rsp_id_q    <= owner;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cool        <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_ctl   = alu_ctl_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Bench for alu_arbiter: provides a behavioural ALU, drives both
//   requesters and the response consumer, and scores every response against
//   expectations queued at request acceptance.
module tb_alu_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- ALU model ----------------
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0010: alu_f = a + b;
      4'b0110: alu_f = a - b;
      4'b0111: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: alu_f = ~(a | b);
      default: alu_f = 32'd0;
    endcase
  endfunction

  assign bus.alu_out  = alu_f(bus.alu_ctl, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = (bus.alu_out == 32'd0);

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  // expected word = {id, zero, data}
  logic [33:0] exp_q[$];
  int          acc_q[$];      // acceptance cycles awaiting rsp_valid rise
  int          acc_log[$];    // all acceptance cycles since reset
  logic        grant_q[$];    // granted ids since reset
  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;
  logic [33:0] prev_word  = '0;

  function automatic logic [33:0] mk_exp(input logic id, input logic [3:0] c,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = alu_f(c, a, b);
    mk_exp = {id, (d == 32'd0), d};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      acc_log.delete();
      grant_q.delete();
      prev_valid <= 1'b0;
      prev_hs    <= 1'b0;
    end else begin
      if (bus.req0_ready || bus.req1_ready) begin
        chk("ready_excl", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
        chk("ready_while_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        chk("ready_needs_valid",
            {63'd0, bus.req1_ready ? bus.req1_valid : bus.req0_valid}, 64'd1);
        if (bus.req1_ready)
          exp_q.push_back(mk_exp(1'b1, bus.req1_ctl, bus.req1_a, bus.req1_b));
        else
          exp_q.push_back(mk_exp(1'b0, bus.req0_ctl, bus.req0_a, bus.req0_b));
        acc_q.push_back(cyc);
        acc_log.push_back(cyc);
        grant_q.push_back(bus.req1_ready);
      end
      if (bus.rsp_valid && !prev_valid) begin
        if (acc_q.size() > 0)
          chk("rsp_latency", 64'(cyc - acc_q.pop_front()), 64'd2);
        else
          chk("rsp_unexpected", 64'd1, 64'd0);
      end
      if (bus.rsp_valid && prev_valid && !prev_hs)
        chk("rsp_stable", {30'd0, bus.rsp_id, bus.rsp_zero, bus.rsp_data}, {30'd0, prev_word});
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() > 0)
          chk("sb_rsp", {30'd0, bus.rsp_id, bus.rsp_zero, bus.rsp_data}, {30'd0, exp_q.pop_front()});
        else
          chk("sb_empty", 64'd1, 64'd0);
      end
      prev_valid <= bus.rsp_valid;
      prev_hs    <= bus.rsp_valid & bus.rsp_ready;
      prev_word  <= {bus.rsp_id, bus.rsp_zero, bus.rsp_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic set_req(input logic id, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_ctl = c; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_ctl = c; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Present one request and hold it until accepted, then drop valid.
  task automatic send(input logic id, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b);
    logic seen;
    seen = 1'b0;
    set_req(id, c, a, b);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("send_accept", {63'd0, seen}, 64'd1);
    tick(1);
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    chk("wait_rsp", {63'd0, bus.rsp_valid}, 64'd1);
  endtask

  // Directed single operation with constant expectations.
  task automatic run_one(input string tag, input logic id, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input logic ez);
    bus.rsp_ready = 1'b1;
    send(id, c, a, b);
    wait_rsp();
    chk({tag, "_data"}, {32'd0, bus.rsp_data}, {32'd0, ed});
    chk({tag, "_zero"}, {63'd0, bus.rsp_zero}, {63'd0, ez});
    chk({tag, "_id"},   {63'd0, bus.rsp_id},   {63'd0, id});
    tick(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy0"},  {63'd0, bus.req0_ready}, 64'd0);
    chk({tag, "_rdy1"},  {63'd0, bus.req1_ready}, 64'd0);
    chk({tag, "_ctl"},   {60'd0, bus.alu_ctl},    64'd0);
    chk({tag, "_a"},     {32'd0, bus.alu_a},      64'd0);
    chk({tag, "_b"},     {32'd0, bus.alu_b},      64'd0);
    chk({tag, "_valid"}, {63'd0, bus.rsp_valid},  64'd0);
    chk({tag, "_id"},    {63'd0, bus.rsp_id},     64'd0);
    chk({tag, "_data"},  {32'd0, bus.rsp_data},   64'd0);
    chk({tag, "_zero"},  {63'd0, bus.rsp_zero},   64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] ctls [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111};
  logic [31:0] held;

  initial begin
    bus.req0_ctl = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_ctl = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b0;

    // reset state, with both requesters asking throughout reset
    rst = 1'b1;
    set_req(1'b0, 4'b0010, 32'd1, 32'd1);
    set_req(1'b1, 4'b0010, 32'd2, 32'd2);
    tick(2);
    chk_reset_outputs("reset");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;

    // single ADD from requester 0
    run_one("add", 1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0);
    tick(2);

    // both continuously valid: strict alternation, 4-cycle spacing
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 4'b0010, 32'd5, 32'd7);
    set_req(1'b1, 4'b0110, 32'd9, 32'd9);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant_q.size() >= 6) break;
    end
    chk("alt_count", {63'd0, grant_q.size() >= 6}, 64'd1);
    tick(1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick(8);
    for (int i = 0; i < 6; i++)
      chk($sformatf("alt_gnt%0d", i), {63'd0, grant_q[i]}, 64'(i % 2));
    for (int i = 1; i < 6; i++)
      chk($sformatf("alt_gap%0d", i), 64'(acc_log[i] - acc_log[i-1]), 64'd4);
    run_one("sub_eq", 1'b1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1);
    tick(2);

    // SLT and an undefined control code
    run_one("slt", 1'b0, 4'b0111, 32'd3, 32'd8, 32'd1, 1'b0);
    tick(2);
    run_one("undef", 1'b1, 4'b1111, 32'd77, 32'd5, 32'd0, 1'b1);
    tick(2);

    // backpressure: response held 5 cycles, no new acceptance meanwhile
    bus.rsp_ready = 1'b0;
    send(1'b0, 4'b0010, 32'd100, 32'd23);
    wait_rsp();
    set_req(1'b1, 4'b0001, 32'hf0, 32'h0f);
    held = bus.rsp_data;
    chk("bp_data", {32'd0, held}, 64'd123);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_hold",  {32'd0, bus.rsp_data},  {32'd0, held});
      chk("bp_rdy",   {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
      chk("bp_state", {62'd0, bus.state_dbg}, 64'd2);
    end
    tick(1);
    bus.rsp_ready = 1'b1;
    send(1'b1, 4'b0001, 32'hf0, 32'h0f);
    wait_rsp();
    chk("bp_next", {32'd0, bus.rsp_data}, 64'hff);
    tick(3);

    // reset pulse in RESP after a requester-0 grant
    bus.rsp_ready = 1'b0;
    send(1'b0, 4'b0001, 32'd1, 32'd2);
    wait_rsp();
    set_req(1'b0, 4'b0000, 32'hff, 32'h0f);
    set_req(1'b1, 4'b1100, 32'd0, 32'd0);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("rst_resp");
    tick(2);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_first_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    chk("rst_first_rdy1", {63'd0, bus.req1_ready}, 64'd0);
    tick(1);
    bus.req0_valid = 1'b0;
    wait_rsp();
    chk("rst_next_id",   {63'd0, bus.rsp_id},   64'd0);
    chk("rst_next_data", {32'd0, bus.rsp_data}, 64'h0f);
    tick(1);
    send(1'b1, 4'b1100, 32'd0, 32'd0);
    wait_rsp();
    chk("rst_nor_data", {32'd0, bus.rsp_data}, 64'hffffffff);
    tick(3);

    // random traffic, payload and backpressure all change every cycle
    for (int i = 0; i < 600; i++) begin
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req0_ctl   = ctls[$urandom_range(0, 6)];
      bus.req0_a     = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 9));
      bus.req0_b     = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 9));
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req1_ctl   = ctls[$urandom_range(0, 6)];
      bus.req1_a     = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 9));
      bus.req1_b     = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 9));
      bus.rsp_ready  = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    tick(10);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time limit
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
